// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO between the terminal core and a uart transmitter.
//            Bytes are pushed at any rate. They are popped one at a time and
//            handed to the uart as a one-cycle transmit pulse plus a held byte.
//            The block then waits for the uart's is_transmitting to rise and
//            fall before it launches the next byte. Overflow and
//            unacknowledged launches are flagged in sticky flags.
// Ports    : clk_i            system clock, rising edge
//            rst_ni           asynchronous active-low reset
//            wr_en_i/wr_data_i push request and byte
//            full_o/empty_o/level_o  FIFO occupancy, derived from level register
//            overflow_o       sticky, push attempted while full
//            tx_lost_o        sticky, launch not acknowledged in ARM_TIMEOUT
//            clr_flags_i      clears both sticky flags (set has priority)
//            uart_transmit_o  one-cycle launch pulse
//            uart_tx_byte_o   launched byte, held until the next launch
//            uart_busy_i      uart is_transmitting
//            busy_o           FSM active or FIFO not empty
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [7:0]        wr_data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o,
  output logic              tx_lost_o,
  input  logic              clr_flags_i,
  output logic              uart_transmit_o,
  output logic [7:0]        uart_tx_byte_o,
  input  logic              uart_busy_i,
  output logic              busy_o
);

  localparam logic [1:0]        c_ST_IDLE  = 2'd0;
  localparam logic [1:0]        c_ST_ARM   = 2'd1;
  localparam logic [1:0]        c_ST_DRAIN = 2'd2;
  localparam logic [3:0]        c_ARM_TO   = 4'(ARM_TIMEOUT);
  localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [3:0]        timer_q, timer_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              tx_lost_q, tx_lost_d;
  logic              transmit_q, transmit_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        mem_q [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_lost;

  // Occupancy comes only from the level register, so a pop in the same
  // cycle never makes room for a push.
  assign w_full  = (level_q == c_DEPTH);
  assign w_empty = (level_q == '0);
  assign w_push  = wr_en_i && !w_full;

  // --------------------------------------------------------------------------
  // State register (FSM plus FIFO bookkeeping)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= c_ST_IDLE;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_lost_q  <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tx_lost_q  <= tx_lost_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    w_pop      = 1'b0;
    w_lost     = 1'b0;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    case (state_q)
      c_ST_IDLE: begin
        if (!w_empty && !uart_busy_i) begin
          w_pop      = 1'b1;
          tx_byte_d  = mem_q[rd_ptr_q];
          transmit_d = 1'b1;
          timer_d    = '0;
          state_d    = c_ST_ARM;
        end
      end
      c_ST_ARM: begin
        if (uart_busy_i) begin
          state_d = c_ST_DRAIN;
        end else begin
          timer_d = timer_q + 4'd1;
          // The popped byte is abandoned, not retried.
          if (timer_d == c_ARM_TO) begin
            w_lost  = 1'b1;
            state_d = c_ST_IDLE;
          end
        end
      end
      c_ST_DRAIN: begin
        if (!uart_busy_i) begin
          state_d = c_ST_IDLE;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase

    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Setting a sticky flag wins over a same-cycle clear.
    if (wr_en_i && w_full) begin
      overflow_d = 1'b1;
    end else if (clr_flags_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (w_lost) begin
      tx_lost_d = 1'b1;
    end else if (clr_flags_i) begin
      tx_lost_d = 1'b0;
    end else begin
      tx_lost_d = tx_lost_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    full_o          = w_full;
    empty_o         = w_empty;
    level_o         = level_q;
    overflow_o      = overflow_q;
    tx_lost_o       = tx_lost_q;
    uart_transmit_o = transmit_q;
    uart_tx_byte_o  = tx_byte_q;
    busy_o          = (state_q != c_ST_IDLE) || !w_empty;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo with a simple uart
//            model. The model raises busy one cycle after a pulse and keeps it
//            high for 10 cycles. It can also be told never to acknowledge.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr = 1'b0;
  logic       full, empty, overflow, tx_lost, transmit, busy;
  logic [4:0] level;
  logic [7:0] tx_byte;
  logic       uart_busy;

  logic       hold_busy = 1'b0;
  logic       never_ack = 1'b0;
  int         bcnt = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  int checks = 0;
  int failures = 0;
  int maxlvl;
  int sent;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4), .ARM_TIMEOUT(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .wr_en_i         (wr_en),
    .wr_data_i       (wr_data),
    .full_o          (full),
    .empty_o         (empty),
    .level_o         (level),
    .overflow_o      (overflow),
    .tx_lost_o       (tx_lost),
    .clr_flags_i     (clr),
    .uart_transmit_o (transmit),
    .uart_tx_byte_o  (tx_byte),
    .uart_busy_i     (uart_busy),
    .busy_o          (busy)
  );

  // Uart model: records every launched byte.
  assign uart_busy = (bcnt != 0) || hold_busy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= 0;
    end else if (transmit) begin
      rx_q.push_back(tx_byte);
      if (!never_ack) bcnt <= 10;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int k = 0; k < budget && busy; k++) tick();
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // ---------------- reset ----------------
    #1 rst_n = 1'b0;
    #11;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_lost", tx_lost, 0);
    chk("rst_transmit", transmit, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // ---------------- 1: single byte ----------------
    rx_q.delete();
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    wr_en = 1'b0;
    chk("t1_empty_after_push", empty, 0);
    chk("t1_level_after_push", level, 1);
    chk("t1_no_pulse_yet", transmit, 0);
    tick();
    chk("t1_pulse", transmit, 1);
    chk("t1_byte", tx_byte, 8'h41);
    chk("t1_level_after_pop", level, 0);
    tick();
    chk("t1_pulse_one_cycle", transmit, 0);
    wait_idle("t1_drain_timeout", 100);
    chk("t1_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t1_rx_byte", rx_q[0], 8'h41);
    chk("t1_byte_held", tx_byte, 8'h41);

    // ---------------- 2: fill to full, drain in order ----------------
    rx_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      tick();
      if (i == 14) chk("t2_not_full_at_15", full, 0);
    end
    wr_en = 1'b0;
    chk("t2_full", full, 1);
    chk("t2_level16", level, 16);
    hold_busy = 1'b0;
    wait_idle("t2_drain_timeout", 600);
    chk("t2_overflow", overflow, 0);
    chk("t2_rx_count", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      chk($sformatf("t2_rx_%0d", i), rx_q[i], 8'h30 + 8'(i));

    // ---------------- 3: push while full with same-cycle pop ----------------
    rx_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
      tick();
    end
    wr_data = 8'hFF;
    hold_busy = 1'b0;
    tick();
    wr_en = 1'b0;
    chk("t3_overflow_set", overflow, 1);
    chk("t3_level15", level, 15);
    chk("t3_pop_pulse", transmit, 1);
    chk("t3_pop_byte", tx_byte, 8'h50);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_overflow_clr", overflow, 0);
    wait_idle("t3_drain_timeout", 600);
    chk("t3_rx_count", rx_q.size(), 16);
    if (rx_q.size() == 16) chk("t3_rx_last", rx_q[15], 8'h5F);

    // ---------------- 4: launch never acknowledged ----------------
    never_ack = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA1;
    tick();                      // N
    wr_data = 8'hA2;
    tick();                      // N+1
    wr_en = 1'b0;
    chk("t4_pulse_a1", transmit, 1);
    chk("t4_byte_a1", tx_byte, 8'hA1);
    tick(); tick(); tick();      // N+4
    chk("t4_no_lost_yet", tx_lost, 0);
    tick();                      // N+5
    chk("t4_lost_set", tx_lost, 1);
    chk("t4_busy_queued", busy, 1);
    tick();                      // N+6
    chk("t4_pulse_a2", transmit, 1);
    chk("t4_byte_a2", tx_byte, 8'hA2);
    tick(); tick(); tick(); tick();  // N+10
    chk("t4_lost_still", tx_lost, 1);
    chk("t4_idle", busy, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_lost_clr", tx_lost, 0);

    // ---------------- 5: reset during ARM ----------------
    wr_en = 1'b1; wr_data = 8'hC1; tick();
    wr_data = 8'hC2; tick();
    wr_data = 8'hC3; tick();
    wr_data = 8'hC4; tick();
    wr_en = 1'b0;
    chk("t5_level3", level, 3);
    chk("t5_in_arm_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_level", level, 0);
    chk("t5_rst_empty", empty, 1);
    chk("t5_rst_transmit", transmit, 0);
    chk("t5_rst_byte", tx_byte, 8'h00);
    chk("t5_rst_busy", busy, 0);
    rx_q.delete();
    never_ack = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("t5_no_pulse_after", rx_q.size(), 0);
    chk("t5_level_after", level, 0);
    chk("t5_empty_after", empty, 1);

    // ---------------- 6: streaming across two pointer wraps ----------------
    rx_q.delete();
    exp_q.delete();
    maxlvl = 0;
    sent = 0;
    for (int k = 0; k < 3000 && (sent < 36 || busy); k++) begin
      if (sent < 36 && !full) begin
        wr_en = 1'b1;
        wr_data = 8'(sent * 7 + 3);
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    wr_en = 1'b0;
    chk("t6_all_sent", sent, 36);
    chk("t6_drain_timeout", busy, 0);
    chk("t6_level_bound", {31'd0, maxlvl <= 16}, 1);
    chk("t6_overflow", overflow, 0);
    chk("t6_rx_count", rx_q.size(), 36);
    for (int i = 0; i < 36 && i < rx_q.size(); i++)
      chk($sformatf("t6_rx_%0d", i), rx_q[i], exp_q[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
